// File: rtl/axgpio_regs.sv
// GPIO register block behind the AXI-Lite read/write channel stages.
// Combinational read decode, single-cycle write strobes, synchronised inputs
// with per-pin edge-detect interrupts.
module axgpio_regs #(
    parameter int unsigned GPIO_W      = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              iCLK,
    input  logic              iRST,
    // Read channel
    input  logic [7:0]        iPRADR,
    output logic [31:0]       oPRDAT,
    output logic              oPERR,
    // Write channel
    input  logic              iPWEN,
    input  logic [7:0]        iPWADR,
    input  logic [31:0]       iPWDAT,
    input  logic [3:0]        iPWSTRB,
    output logic              oPWERR,
    // Pins
    input  logic [GPIO_W-1:0] iGPIO_IN,
    output logic [GPIO_W-1:0] oGPIO_OUT,
    output logic [GPIO_W-1:0] oGPIO_OE,
    output logic              oIRQ
);

    localparam logic [7:0] ADR_DATA_IN  = 8'h00;
    localparam logic [7:0] ADR_DATA_OUT = 8'h04;
    localparam logic [7:0] ADR_DIR      = 8'h08;
    localparam logic [7:0] ADR_IER      = 8'h0C;
    localparam logic [7:0] ADR_ISR      = 8'h10;
    localparam logic [7:0] ADR_POL      = 8'h14;
    localparam logic [7:0] ADR_SET      = 8'h18;
    localparam logic [7:0] ADR_CLR      = 8'h1C;

    // Register state; sized to GPIO_W so upper register bits read 0 and drop writes
    logic [GPIO_W-1:0] dataOutQ, dataOutD;
    logic [GPIO_W-1:0] dirQ, dirD;
    logic [GPIO_W-1:0] ierQ, ierD;
    logic [GPIO_W-1:0] isrQ, isrD;
    logic [GPIO_W-1:0] polQ, polD;
    logic              irqQ, irqD;
    logic              pwerrQ, pwerrD;

    // Input path
    logic [GPIO_W-1:0] syncQ [SYNC_STAGES];
    logic [GPIO_W-1:0] prevQ;
    logic [GPIO_W-1:0] syncOut;
    logic [GPIO_W-1:0] riseEdge;
    logic [GPIO_W-1:0] fallEdge;
    logic [GPIO_W-1:0] edgeHit;

    // Write datapath helpers
    logic [31:0]       byteMask;
    logic [GPIO_W-1:0] wrMask;
    logic [GPIO_W-1:0] wrBits;
    logic [GPIO_W-1:0] w1cBits;
    logic              wrErr;

    // Read data before zero-extension to the bus width
    logic [31:0]       rdWide;

    assign syncOut = syncQ[SYNC_STAGES-1];

    // Input synchroniser chain plus one history stage for edge detection
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                syncQ[i] <= '0;
            end
            prevQ <= '0;
        end else begin
            syncQ[0] <= iGPIO_IN;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                syncQ[i] <= syncQ[i-1];
            end
            prevQ <= syncOut;
        end
    end

    // Edge detect: POL selects rising (0) or falling (1); driven pins are ignored
    always_comb begin
        riseEdge = syncOut & ~prevQ;
        fallEdge = ~syncOut & prevQ;
        edgeHit  = ((riseEdge & ~polQ) | (fallEdge & polQ)) & ~dirQ;
    end

    // Byte-enable expansion of the write strobe
    always_comb begin
        byteMask = '0;
        for (int b = 0; b < 4; b++) begin
            byteMask[8*b +: 8] = {8{iPWSTRB[b]}};
        end
        wrMask = byteMask[GPIO_W-1:0];
        wrBits = iPWDAT[GPIO_W-1:0] & wrMask;
    end

    // Write address decode: only the writable offsets are legal targets
    always_comb begin
        wrErr = 1'b1;
        case (iPWADR)
            ADR_DATA_OUT, ADR_DIR, ADR_IER, ADR_ISR,
            ADR_POL, ADR_SET, ADR_CLR: wrErr = 1'b0;
            default:                   wrErr = 1'b1;
        endcase
    end

    // Register next-state: strobed writes, W1C, edge capture, irq and error pulse
    always_comb begin
        dataOutD = dataOutQ;
        dirD     = dirQ;
        ierD     = ierQ;
        polD     = polQ;
        w1cBits  = '0;
        if (iPWEN && !wrErr) begin
            case (iPWADR)
                ADR_DATA_OUT: dataOutD = (dataOutQ & ~wrMask) | wrBits;
                ADR_DIR:      dirD     = (dirQ & ~wrMask) | wrBits;
                ADR_IER:      ierD     = (ierQ & ~wrMask) | wrBits;
                ADR_ISR:      w1cBits  = wrBits;
                ADR_POL:      polD     = (polQ & ~wrMask) | wrBits;
                ADR_SET:      dataOutD = dataOutQ | wrBits;
                ADR_CLR:      dataOutD = dataOutQ & ~wrBits;
                default:      ;
            endcase
        end
        // A fresh edge overrides a same-cycle clear
        isrD   = (isrQ & ~w1cBits) | edgeHit;
        irqD   = |(isrQ & ierQ);
        pwerrD = iPWEN & wrErr;
    end

    // Register state update
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dataOutQ <= '0;
            dirQ     <= '0;
            ierQ     <= '0;
            isrQ     <= '0;
            polQ     <= '0;
            irqQ     <= 1'b0;
            pwerrQ   <= 1'b0;
        end else begin
            dataOutQ <= dataOutD;
            dirQ     <= dirD;
            ierQ     <= ierD;
            isrQ     <= isrD;
            polQ     <= polD;
            irqQ     <= irqD;
            pwerrQ   <= pwerrD;
        end
    end

    // Zero-latency read mux; anything not a mapped aligned offset is an error
    always_comb begin
        rdWide = '0;
        oPERR  = 1'b0;
        case (iPRADR)
            ADR_DATA_IN:      rdWide[GPIO_W-1:0] = syncOut;
            ADR_DATA_OUT:     rdWide[GPIO_W-1:0] = dataOutQ;
            ADR_DIR:          rdWide[GPIO_W-1:0] = dirQ;
            ADR_IER:          rdWide[GPIO_W-1:0] = ierQ;
            ADR_ISR:          rdWide[GPIO_W-1:0] = isrQ;
            ADR_POL:          rdWide[GPIO_W-1:0] = polQ;
            ADR_SET, ADR_CLR: rdWide = '0;
            default:          oPERR = 1'b1;
        endcase
        oPRDAT = rdWide;
    end

    assign oGPIO_OUT = dataOutQ;
    assign oGPIO_OE  = dirQ;
    assign oIRQ      = irqQ;
    assign oPWERR    = pwerrQ;

endmodule

// File: doc/axgpio_regs.md
# axgpio_regs

GPIO register block sitting directly downstream of the AXI-Lite read and write channel stages. It decodes the 8-bit register address driven by the read channel, returns read data and an error flag with zero added latency, and accepts single-cycle write strobes from the write channel. It owns the GPIO pin state, including:
- input synchronisation
- output and direction registers
- edge-detect interrupts

## Interface
- GPIO_W, 32, number of GPIO pins (1..32); register bits at and above GPIO_W read 0 and ignore writes
- SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iPRADR  in  8  read byte address from read channel
- oPRDAT  out  32  read data, combinational from iPRADR and register state
- oPERR  out  1  read error, combinational: unmapped or misaligned iPRADR
- iPWEN  in  1  write strobe, one cycle per write
- iPWADR  in  8  write byte address
- iPWDAT  in  32  write data
- iPWSTRB  in  4  byte enables for iPWDAT
- oPWERR  out  1  write error pulse, registered, one cycle after the offending iPWEN
- iGPIO_IN  in  GPIO_W  asynchronous pin inputs
- oGPIO_OUT  out  GPIO_W  output data (DATA_OUT)
- oGPIO_OE  out  GPIO_W  output enable (DIR; 1 = drive)
- oIRQ  out  1  registered interrupt request

## Operation
Register map (byte offsets):
- 0x00 DATA_IN: read-only, synchroniser output
- 0x04 DATA_OUT: read/write
- 0x08 DIR: read/write
- 0x0C IER: read/write, interrupt enable
- 0x10 ISR: write-1-to-clear, interrupt status
- 0x14 POL: read/write; 0 = rising-edge detect, 1 = falling-edge detect
- 0x18 SET: write-only, reads 0; DATA_OUT |= wdata
- 0x1C CLR: write-only, reads 0; DATA_OUT &= ~wdata

Read decode:
- Addresses 0x20..0xFF, or any address with adr[1:0] != 0, give oPERR=1 and oPRDAT=0.
- Reads have no side effects; ISR is not cleared by read. The idle address 0x00 is therefore always safe to present.

Write handling:
- Writes apply only bytes whose iPWSTRB bit is set. For SET/CLR, unstrobed bytes are unaffected.
- Writes to 0x00 DATA_IN are an error.
- Writes to an unmapped address are an error.
- Writes to a misaligned address are an error.
- Any erroring write changes no state and raises oPWERR.
- A write with iPWSTRB=0 to a valid address is not an error and changes nothing.

Input and interrupt path:
- Inputs pass through SYNC_STAGES flops (sync), then one history flop (prev).
- Edge per pin: rising = sync & ~prev; falling = ~sync & prev; selected by POL.
- Edges are only recorded on pins with DIR=0.
- ISR bit sets on a detected edge regardless of IER.
- oIRQ <= |(ISR & IER & pin mask).

Simultaneous events:
- Edge detect and W1C on the same ISR bit in the same cycle: set wins, bit stays 1.
- POL write while an edge is pending: the new POL applies from the following cycle.

## Timing
- Reset (async assert, release synchronised by the surrounding design): all registers, synchroniser and history flops 0.
- Outputs during reset: oGPIO_OUT=0, oGPIO_OE=0, oIRQ=0, oPWERR=0.
- Read: oPRDAT/oPERR valid in the same cycle as iPRADR; zero latency.
- Write: register updated at the clock edge where iPWEN=1; new value readable the next cycle.
- oGPIO_OUT/oGPIO_OE are driven directly from flops; they change one edge after the write.
- Input latency: a pin change is visible in DATA_IN after SYNC_STAGES rising edges.
- The matching ISR bit sets one edge after that (SYNC_STAGES+1).
- oIRQ follows ISR/IER by one further edge.
- Clearing ISR or IER deasserts oIRQ one edge after the clearing write.
- Back-to-back iPWEN every cycle is supported; each write is independent.
- Reset mid-operation clears all state immediately, including a pending edge and a pending oPWERR.

## Test plan
- Reset then read 0x00..0x1C → all read 0, oPERR=0; read 0x20 and 0x05 → oPERR=1, oPRDAT=0.
- Write DIR=0x0000_00FF, then DATA_OUT=0xA5 with iPWSTRB=4'b0001 → oGPIO_OE=0xFF and oGPIO_OUT=0xA5 one cycle later. SET 0x0A → 0xAF; CLR 0x0F → 0xA0.
- With DIR=0, POL=0, IER=0x1, raise iGPIO_IN[0] → DATA_IN[0]=1 after 2 edges, ISR[0]=1 after 3, oIRQ=1 after 4. W1C 0x1 to ISR → oIRQ=0 one cycle later.
- Falling edge on pin 3 with POL[3]=1 while a W1C of ISR[3] hits the same cycle → ISR[3] remains 1.
- Write 0xFFFF_FFFF to 0x00 → oPWERR pulses one cycle and DATA_IN is unaffected. Write to 0x24 → oPWERR, no state change.
- Assert iRST mid-stream with ISR, DATA_OUT and DIR nonzero → all outputs 0 asynchronously; the first read after release returns 0.
